// File: rtl/data_mem_stage.sv
// MEM-stage data memory for the RV64I pipeline: byte-addressed little-endian RAM with
// combinational sized loads, registered stores, legality checking, sticky error and store counter.
module data_mem_stage #(
  parameter int DEPTH_BYTES = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       funct3,
  input  logic [63:0]      Address,
  input  logic [63:0]      WriteData,
  output logic [63:0]      ReadData,
  output logic             access_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] store_count
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]       r_mem [DEPTH_BYTES];
  logic             r_errSticky;
  logic [CNT_W-1:0] r_storeCount;

  logic [3:0]    w_size;
  logic [7:0]    w_byteEn;
  logic          w_f3Ok;
  logic          w_aligned;
  logic          w_inRange;
  logic          w_active;
  logic          w_legal;
  logic          w_doLoad;
  logic          w_doStore;
  logic [AW-1:0] w_offset;
  logic [AW:0]   w_end;
  logic [AW-1:0] w_idx [8];
  logic [63:0]   w_raw;
  logic [63:0]   w_ext;

  assign w_offset = Address[AW-1:0];

  // funct3[1:0] encodes the access size; bit 2 selects zero-extension and is load-only
  always_comb begin
    w_size    = 4'd1;
    w_byteEn  = 8'h01;
    w_aligned = 1'b1;
    case (funct3[1:0])
      2'b00: begin w_size = 4'd1; w_byteEn = 8'h01; w_aligned = 1'b1; end
      2'b01: begin w_size = 4'd2; w_byteEn = 8'h03; w_aligned = (Address[0] == 1'b0); end
      2'b10: begin w_size = 4'd4; w_byteEn = 8'h0F; w_aligned = (Address[1:0] == 2'b00); end
      default: begin w_size = 4'd8; w_byteEn = 8'hFF; w_aligned = (Address[2:0] == 3'b000); end
    endcase
    w_f3Ok = MemWrite ? !funct3[2] : (funct3 != 3'b111);
  end

  assign w_end      = {1'b0, w_offset} + (AW+1)'(w_size);
  assign w_inRange  = (Address[63:AW] == '0) && (w_end <= (AW+1)'(DEPTH_BYTES));
  assign w_active   = MemRead || MemWrite;
  assign w_legal    = !(MemRead && MemWrite) && w_f3Ok && w_aligned && w_inRange;
  assign access_err = w_active && !w_legal;
  assign w_doLoad   = MemRead && w_legal;
  assign w_doStore  = MemWrite && w_legal;

  // Byte lane i always maps to Address+i; indices wrap so idle/illegal cycles never index past the array
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < 8; i++) begin
      w_idx[i]         = w_offset + AW'(i);
      w_raw[8*i +: 8] = r_mem[w_idx[i]];
    end
  end

  always_comb begin
    w_ext = w_raw;
    case (funct3)
      3'b000:  w_ext = {{56{w_raw[7]}},  w_raw[7:0]};
      3'b001:  w_ext = {{48{w_raw[15]}}, w_raw[15:0]};
      3'b010:  w_ext = {{32{w_raw[31]}}, w_raw[31:0]};
      3'b100:  w_ext = {56'd0, w_raw[7:0]};
      3'b101:  w_ext = {48'd0, w_raw[15:0]};
      3'b110:  w_ext = {32'd0, w_raw[31:0]};
      default: w_ext = w_raw;
    endcase
  end

  assign ReadData = w_doLoad ? w_ext : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= 8'd0;
      r_errSticky  <= 1'b0;
      r_storeCount <= '0;
    end else begin
      if (access_err) r_errSticky <= 1'b1;
      if (w_doStore) begin
        for (int i = 0; i < 8; i++) begin
          if (w_byteEn[i]) r_mem[w_idx[i]] <= WriteData[8*i +: 8];
        end
        r_storeCount <= r_storeCount + CNT_W'(1);
      end
    end
  end

  assign err_sticky  = r_errSticky;
  assign store_count = r_storeCount;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: table-driven load/store vectors plus
// hand-written sequences for sticky error, reset behaviour and counter wrap.
module tb_data_mem_stage;
  localparam int DEPTH = 256;
  localparam int CNT_W = 4;

  localparam logic [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_D = 3'd3;
  localparam logic [2:0] F_BU = 3'd4, F_HU = 3'd5, F_WU = 3'd6, F_X = 3'd7;

  logic             clk = 1'b0;
  logic             reset;
  logic             MemRead;
  logic             MemWrite;
  logic [2:0]       funct3;
  logic [63:0]      Address;
  logic [63:0]      WriteData;
  logic [63:0]      ReadData;
  logic             access_err;
  logic             err_sticky;
  logic [CNT_W-1:0] store_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  data_mem_stage #(.DEPTH_BYTES(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .access_err(access_err), .err_sticky(err_sticky),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    Address   = addr;
    WriteData = wdata;
    #1;
  endtask

  task automatic addLoad(input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] exp, input logic err);
    vecs.push_back('{1'b1, 1'b0, f3, addr, 64'd0, exp, err});
  endtask

  task automatic addStore(input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic err);
    vecs.push_back('{1'b0, 1'b1, f3, addr, wdata, 64'd0, err});
  endtask

  task automatic runVecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("%s%0d data", tag, i), ReadData, vecs[i].expData);
      checkOutput($sformatf("%s%0d err", tag, i), {63'd0, access_err}, {63'd0, vecs[i].expErr});
    end
    vecs.delete();
  endtask

  initial begin
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0; Address = 64'd0; WriteData = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, F_D, 64'h0, 64'd0);
    checkOutput("reset ld data", ReadData, 64'd0);
    checkOutput("reset ld err", {63'd0, access_err}, 64'd0);
    checkOutput("reset sticky", {63'd0, err_sticky}, 64'd0);
    checkOutput("reset count", {60'd0, store_count}, 64'd0);

    // Legal loads and stores of every size and extension
    addStore(F_D,  64'h10, 64'h8877665544332211, 1'b0);
    addLoad (F_B,  64'h10, 64'h0000000000000011, 1'b0);
    addLoad (F_H,  64'h12, 64'h0000000000004433, 1'b0);
    addLoad (F_W,  64'h14, 64'hFFFFFFFF88776655, 1'b0);
    addLoad (F_WU, 64'h14, 64'h0000000088776655, 1'b0);
    addLoad (F_D,  64'h10, 64'h8877665544332211, 1'b0);
    addLoad (F_HU, 64'h16, 64'h0000000000008877, 1'b0);
    addLoad (F_H,  64'h16, 64'hFFFFFFFFFFFF8877, 1'b0);
    addStore(F_D,  64'h20, 64'h0706050403020100, 1'b0);
    addStore(F_B,  64'h21, 64'hAAAAAAAAAAAAAA80, 1'b0);
    addLoad (F_B,  64'h21, 64'hFFFFFFFFFFFFFF80, 1'b0);
    addLoad (F_BU, 64'h21, 64'h0000000000000080, 1'b0);
    addLoad (F_B,  64'h20, 64'h0000000000000000, 1'b0);
    addLoad (F_B,  64'h22, 64'h0000000000000002, 1'b0);
    addLoad (F_D,  64'h20, 64'h0706050403028000, 1'b0);
    addStore(F_H,  64'h24, 64'h123456789ABCBEEF, 1'b0);
    addLoad (F_D,  64'h20, 64'h0706BEEF03028000, 1'b0);
    addLoad (F_H,  64'h24, 64'hFFFFFFFFFFFFBEEF, 1'b0);
    addStore(F_W,  64'h28, 64'hFFFFFFFFCAFEF00D, 1'b0);
    addLoad (F_W,  64'h28, 64'hFFFFFFFFCAFEF00D, 1'b0);
    addLoad (F_WU, 64'h28, 64'h00000000CAFEF00D, 1'b0);
    addLoad (F_D,  64'h28, 64'h00000000CAFEF00D, 1'b0);
    runVecs("legal");

    applyStimulus(1'b0, 1'b0, F_D, 64'h10, 64'd0);
    checkOutput("idle data", ReadData, 64'd0);
    checkOutput("idle err", {63'd0, access_err}, 64'd0);
    checkOutput("count after legal", {60'd0, store_count}, 64'd5);
    checkOutput("sticky before err", {63'd0, err_sticky}, 64'd0);

    // Misaligned store: flagged combinationally, sticky one cycle later, memory untouched
    applyStimulus(1'b0, 1'b1, F_W, 64'h22, 64'h0000000011111111);
    checkOutput("misaligned sw err", {63'd0, access_err}, 64'd1);
    checkOutput("misaligned sw data", ReadData, 64'd0);
    applyStimulus(1'b1, 1'b0, F_D, 64'h20, 64'd0);
    checkOutput("sticky after err", {63'd0, err_sticky}, 64'd1);
    checkOutput("count after bad sw", {60'd0, store_count}, 64'd5);
    checkOutput("ld after bad sw", ReadData, 64'h0706BEEF03028000);

    // Range, funct3 and read+write conflicts
    addStore(F_D,  64'hF8, 64'hDEADBEEF00C0FFEE, 1'b0);
    addLoad (F_D,  64'hF8, 64'hDEADBEEF00C0FFEE, 1'b0);
    addLoad (F_W,  64'hFC, 64'hFFFFFFFFDEADBEEF, 1'b0);
    addLoad (F_BU, 64'hFF, 64'h00000000000000DE, 1'b0);
    addStore(F_D,  64'h100, 64'h1111111111111111, 1'b1);
    addLoad (F_D,  64'h100, 64'd0, 1'b1);
    addLoad (F_D,  64'hFC, 64'd0, 1'b1);
    addLoad (F_X,  64'h10, 64'd0, 1'b1);
    addStore(F_BU, 64'h30, 64'h00000000000000AB, 1'b1);
    addLoad (F_D,  64'h8000000000000010, 64'd0, 1'b1);
    vecs.push_back('{1'b1, 1'b1, F_D, 64'h30, 64'h5555555555555555, 64'd0, 1'b1});
    addLoad (F_D,  64'h30, 64'd0, 1'b0);
    addLoad (F_D,  64'hF8, 64'hDEADBEEF00C0FFEE, 1'b0);
    runVecs("range");

    applyStimulus(1'b0, 1'b0, F_B, 64'h0, 64'd0);
    checkOutput("count after range", {60'd0, store_count}, 64'd6);

    // Store in a reset cycle is dropped and all prior contents are cleared
    @(negedge clk);
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b1; funct3 = F_D; Address = 64'h0; WriteData = 64'hFFFFFFFFFFFFFFFF;
    #1;
    checkOutput("err during reset", {63'd0, access_err}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    MemWrite = 1'b0;
    applyStimulus(1'b1, 1'b0, F_D, 64'h0, 64'd0);
    checkOutput("post-reset ld 0", ReadData, 64'd0);
    checkOutput("post-reset count", {60'd0, store_count}, 64'd0);
    checkOutput("post-reset sticky", {63'd0, err_sticky}, 64'd0);
    applyStimulus(1'b1, 1'b0, F_D, 64'h10, 64'd0);
    checkOutput("post-reset ld 10", ReadData, 64'd0);

    // Sixteen legal stores wrap a 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, F_B, 64'(i), 64'(i + 1));
      if (i == 15) checkOutput("count before wrap", {60'd0, store_count}, 64'd15);
    end
    applyStimulus(1'b1, 1'b0, F_B, 64'h0F, 64'd0);
    checkOutput("count wrapped", {60'd0, store_count}, 64'd0);
    checkOutput("ld last wrap byte", ReadData, 64'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
